// File: rtl/rv32_decode_stage_pkg.sv
// rv32_decode_stage_pkg: shared RV32I decode enums, ALU op codes, decode-entry struct and per-opcode helpers.
package rv32_decode_stage_pkg;
  typedef enum logic [5:0] {
    RV32_UNKNOWN, RV32_NOP, RV32_LUI, RV32_AUIPC, RV32_JAL, RV32_JALR,
    RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU,
    RV32_LB, RV32_LH, RV32_LW, RV32_LBU, RV32_LHU, RV32_SB, RV32_SH, RV32_SW,
    RV32_ADDI, RV32_SLTI, RV32_SLTIU, RV32_XORI, RV32_ORI, RV32_ANDI,
    RV32_SLLI, RV32_SRLI, RV32_SRAI,
    RV32_ADD, RV32_SUB, RV32_SLL, RV32_SLT, RV32_SLTU, RV32_XOR,
    RV32_SRL, RV32_SRA, RV32_OR, RV32_AND,
    RV32_FENCE, RV32_FENCE_I, RV32_ECALL, RV32_EBREAK,
    RV32_CSRRW, RV32_CSRRS, RV32_CSRRC, RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI
  } rv32_opcode_enum_t;
  typedef enum logic [2:0] {
    RV32_TYPE_UNKNOWN, RV32_TYPE_R, RV32_TYPE_I, RV32_TYPE_S,
    RV32_TYPE_B, RV32_TYPE_U, RV32_TYPE_J, RV32_TYPE_NOP
  } rv32_type_enum_t;
  typedef logic [3:0] rv32_alu_op_t;
  localparam rv32_alu_op_t ALU_ADD    = 4'd0;
  localparam rv32_alu_op_t ALU_SUB    = 4'd1;
  localparam rv32_alu_op_t ALU_SLL    = 4'd2;
  localparam rv32_alu_op_t ALU_SLT    = 4'd3;
  localparam rv32_alu_op_t ALU_SLTU   = 4'd4;
  localparam rv32_alu_op_t ALU_XOR    = 4'd5;
  localparam rv32_alu_op_t ALU_SRL    = 4'd6;
  localparam rv32_alu_op_t ALU_SRA    = 4'd7;
  localparam rv32_alu_op_t ALU_OR     = 4'd8;
  localparam rv32_alu_op_t ALU_AND    = 4'd9;
  localparam rv32_alu_op_t ALU_PASS_B = 4'd10;
  typedef enum logic [1:0] {FIFO_EMPTY, FIFO_ONE, FIFO_FULL} fifo_state_t;
  typedef struct packed {
    rv32_opcode_enum_t opcode;
    rv32_type_enum_t   inst_type;
    rv32_alu_op_t      alu_op;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [31:0]       imm;
    logic [11:0]       csr;
    logic [4:0]        zimm;
    logic [3:0]        fence_pred;
    logic [3:0]        fence_succ;
    logic              trap;
  } rv32_entry_t;

  function automatic rv32_type_enum_t op_type(input rv32_opcode_enum_t op);
    case (op)
      RV32_UNKNOWN: return RV32_TYPE_UNKNOWN;
      RV32_NOP: return RV32_TYPE_NOP;
      RV32_LUI, RV32_AUIPC: return RV32_TYPE_U;
      RV32_JAL: return RV32_TYPE_J;
      RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU: return RV32_TYPE_B;
      RV32_SB, RV32_SH, RV32_SW: return RV32_TYPE_S;
      RV32_ADD, RV32_SUB, RV32_SLL, RV32_SLT, RV32_SLTU, RV32_XOR,
      RV32_SRL, RV32_SRA, RV32_OR, RV32_AND: return RV32_TYPE_R;
      default: return RV32_TYPE_I;
    endcase
  endfunction

  function automatic rv32_alu_op_t op_alu(input rv32_opcode_enum_t op);
    case (op)
      RV32_SUB, RV32_BEQ, RV32_BNE: return ALU_SUB;
      RV32_SLT, RV32_SLTI, RV32_BLT, RV32_BGE: return ALU_SLT;
      RV32_SLTU, RV32_SLTIU, RV32_BLTU, RV32_BGEU: return ALU_SLTU;
      RV32_XOR, RV32_XORI: return ALU_XOR;
      RV32_OR, RV32_ORI: return ALU_OR;
      RV32_AND, RV32_ANDI: return ALU_AND;
      RV32_SLL, RV32_SLLI: return ALU_SLL;
      RV32_SRL, RV32_SRLI: return ALU_SRL;
      RV32_SRA, RV32_SRAI: return ALU_SRA;
      RV32_LUI: return ALU_PASS_B;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/rv32_decode_core.sv
// rv32_decode_core: combinational RV32I decode; Zicsr forms decode only when RV32_DECODE_ZICSR_EN is defined.
module rv32_decode_core
  import rv32_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output rv32_entry_t dec
);
  logic [2:0] f3;
  logic [6:0] f7;
  rv32_opcode_enum_t op;
  rv32_type_enum_t ty;
  logic is_zimm;
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  always_comb begin
    op = RV32_UNKNOWN;
    case (instr[6:0])
      7'b0110111: op = RV32_LUI;
      7'b0010111: op = RV32_AUIPC;
      7'b1101111: op = RV32_JAL;
      7'b1100111: op = f3 == 3'b000 ? RV32_JALR : RV32_UNKNOWN;
      7'b1100011:
        case (f3)
          3'b000: op = RV32_BEQ;
          3'b001: op = RV32_BNE;
          3'b100: op = RV32_BLT;
          3'b101: op = RV32_BGE;
          3'b110: op = RV32_BLTU;
          3'b111: op = RV32_BGEU;
          default: op = RV32_UNKNOWN;
        endcase
      7'b0000011:
        case (f3)
          3'b000: op = RV32_LB;
          3'b001: op = RV32_LH;
          3'b010: op = RV32_LW;
          3'b100: op = RV32_LBU;
          3'b101: op = RV32_LHU;
          default: op = RV32_UNKNOWN;
        endcase
      7'b0100011:
        case (f3)
          3'b000: op = RV32_SB;
          3'b001: op = RV32_SH;
          3'b010: op = RV32_SW;
          default: op = RV32_UNKNOWN;
        endcase
      7'b0010011:
        case (f3)
          3'b000: op = instr == 32'h0000_0013 ? RV32_NOP : RV32_ADDI;
          3'b001: op = f7 == 7'h00 ? RV32_SLLI : RV32_UNKNOWN;
          3'b010: op = RV32_SLTI;
          3'b011: op = RV32_SLTIU;
          3'b100: op = RV32_XORI;
          3'b101: op = f7 == 7'h00 ? RV32_SRLI : f7 == 7'h20 ? RV32_SRAI : RV32_UNKNOWN;
          3'b110: op = RV32_ORI;
          default: op = RV32_ANDI;
        endcase
      7'b0110011:
        case ({f7, f3})
          10'h000: op = RV32_ADD;
          10'h100: op = RV32_SUB;
          10'h001: op = RV32_SLL;
          10'h002: op = RV32_SLT;
          10'h003: op = RV32_SLTU;
          10'h004: op = RV32_XOR;
          10'h005: op = RV32_SRL;
          10'h105: op = RV32_SRA;
          10'h006: op = RV32_OR;
          10'h007: op = RV32_AND;
          default: op = RV32_UNKNOWN;
        endcase
      7'b0001111: op = f3 == 3'b000 ? RV32_FENCE : f3 == 3'b001 ? RV32_FENCE_I : RV32_UNKNOWN;
      7'b1110011:
        case (f3)
          3'b000: op = instr == 32'h0000_0073 ? RV32_ECALL : instr == 32'h0010_0073 ? RV32_EBREAK : RV32_UNKNOWN;
`ifdef RV32_DECODE_ZICSR_EN
          3'b001: op = RV32_CSRRW;
          3'b010: op = RV32_CSRRS;
          3'b011: op = RV32_CSRRC;
          3'b101: op = RV32_CSRRWI;
          3'b110: op = RV32_CSRRSI;
          3'b111: op = RV32_CSRRCI;
`endif
          default: op = RV32_UNKNOWN;
        endcase
      default: op = RV32_UNKNOWN;
    endcase
  end
  assign ty = op_type(op);
  assign is_zimm = op inside {RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI};
  assign dec.opcode = op;
  assign dec.inst_type = ty;
  assign dec.alu_op = op_alu(op);
  assign dec.trap = op == RV32_UNKNOWN;
  assign dec.rs1 = ty inside {RV32_TYPE_R, RV32_TYPE_I, RV32_TYPE_S, RV32_TYPE_B} && !is_zimm ? instr[19:15] : '0;
  assign dec.rs2 = ty inside {RV32_TYPE_R, RV32_TYPE_S, RV32_TYPE_B} ? instr[24:20] : '0;
  assign dec.rd = ty inside {RV32_TYPE_R, RV32_TYPE_I, RV32_TYPE_U, RV32_TYPE_J} ? instr[11:7] : '0;
  assign dec.shamt = op inside {RV32_SLLI, RV32_SRLI, RV32_SRAI} ? instr[24:20] : '0;
  assign dec.imm = ty == RV32_TYPE_I ? {{20{instr[31]}}, instr[31:20]}
    : ty == RV32_TYPE_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
    : ty == RV32_TYPE_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
    : ty == RV32_TYPE_U ? {instr[31:12], 12'h000}
    : ty == RV32_TYPE_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
    : '0;
  assign dec.fence_pred = op == RV32_FENCE ? instr[27:24] : '0;
  assign dec.fence_succ = op == RV32_FENCE ? instr[23:20] : '0;
`ifdef RV32_DECODE_ZICSR_EN
  assign dec.csr = op inside {RV32_CSRRW, RV32_CSRRS, RV32_CSRRC, RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI} ? instr[31:20] : '0;
  assign dec.zimm = is_zimm ? instr[19:15] : '0;
`else
  assign dec.csr = '0;
  assign dec.zimm = '0;
`endif
endmodule

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: decode stage with 2-entry skid FIFO and per-hart flush.
// Zicsr decode is enabled by defining RV32_DECODE_ZICSR_EN.
module rv32_decode_stage
  import rv32_decode_stage_pkg::*;
#(
  parameter int NUM_HARTS = 8,
  parameter int HART_W = NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [31:0]         in_pc,
  input  logic [HART_W-1:0]   in_hart,
  input  logic [NUM_HARTS-1:0] flush,
  output logic                out_valid,
  input  logic                out_ready,
  output rv32_opcode_enum_t   out_opcode,
  output rv32_type_enum_t     out_inst_type,
  output rv32_alu_op_t        out_alu_op,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_shamt,
  output logic [31:0]         out_imm,
  output logic [11:0]         out_csr,
  output logic [4:0]          out_zimm,
  output logic [3:0]          out_fence_pred,
  output logic [3:0]          out_fence_succ,
  output logic                out_trap,
  output logic [31:0]         out_pc,
  output logic [HART_W-1:0]   out_hart
);
  typedef struct packed {
    rv32_entry_t       d;
    logic [31:0]       pc;
    logic [HART_W-1:0] hart;
  } slot_t;
  fifo_state_t state, state_n;
  slot_t head, tail, head_n, tail_n, in_slot;
  rv32_entry_t dec;
  logic push, pop, keep0, keep1;
  logic [1:0] cnt;
  rv32_decode_core u_core (.instr(in_instr), .dec(dec));
  assign in_slot = '{d: dec, pc: in_pc, hart: in_hart};
  assign push = in_valid && in_ready && !flush[in_hart];
  assign pop = out_valid && out_ready;
  // a popped head that is also flushed is simply not kept, so it leaves once
  assign keep0 = state != FIFO_EMPTY && !pop && !flush[head.hart];
  assign keep1 = state == FIFO_FULL && !flush[tail.hart];
  always_comb begin
    cnt = 2'(keep0) + 2'(keep1) + 2'(push);
    state_n = cnt == 2'd2 ? FIFO_FULL : cnt == 2'd1 ? FIFO_ONE : FIFO_EMPTY;
    head_n = keep0 ? head : keep1 ? tail : push ? in_slot : '0;
    tail_n = keep0 && keep1 ? tail : (keep0 || keep1) && push ? in_slot : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FIFO_EMPTY;
      head <= '0;
      tail <= '0;
      in_ready <= 1'b1;
    end else begin
      state <= state_n;
      head <= head_n;
      tail <= tail_n;
      in_ready <= state_n != FIFO_FULL;
    end
  end
  assign out_valid = state != FIFO_EMPTY;
  assign out_opcode = head.d.opcode;
  assign out_inst_type = head.d.inst_type;
  assign out_alu_op = head.d.alu_op;
  assign out_rs1 = head.d.rs1;
  assign out_rs2 = head.d.rs2;
  assign out_rd = head.d.rd;
  assign out_shamt = head.d.shamt;
  assign out_imm = head.d.imm;
  assign out_csr = head.d.csr;
  assign out_zimm = head.d.zimm;
  assign out_fence_pred = head.d.fence_pred;
  assign out_fence_succ = head.d.fence_succ;
  assign out_trap = head.d.trap;
  assign out_pc = head.pc;
  assign out_hart = head.hart;
endmodule

// File: tb/tb_rv32_decode_stage.sv
// tb_rv32_decode_stage: directed self-checking bench for rv32_decode_stage.
module tb_rv32_decode_stage;
  import rv32_decode_stage_pkg::*;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, out_trap;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [2:0] in_hart, out_hart;
  logic [7:0] flush;
  rv32_opcode_enum_t out_opcode;
  rv32_type_enum_t out_inst_type;
  rv32_alu_op_t out_alu_op;
  logic [4:0] out_rs1, out_rs2, out_rd, out_shamt, out_zimm;
  logic [11:0] out_csr;
  logic [3:0] out_fence_pred, out_fence_succ;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [31:0] instr;
    rv32_opcode_enum_t op;
    rv32_type_enum_t ty;
    logic [31:0] imm;
    logic [4:0] rs2;
    logic [4:0] shamt;
    logic [7:0] fence;
    logic [11:0] csr;
    logic [4:0] zimm;
    logic trap;
  } vec_t;
  vec_t vq[$];

  rv32_decode_stage #(.NUM_HARTS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_hart(in_hart), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_inst_type(out_inst_type), .out_alu_op(out_alu_op), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_shamt(out_shamt), .out_imm(out_imm),
    .out_csr(out_csr), .out_zimm(out_zimm), .out_fence_pred(out_fence_pred),
    .out_fence_succ(out_fence_succ), .out_trap(out_trap), .out_pc(out_pc),
    .out_hart(out_hart)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] hart);
    in_valid = v;
    in_instr = instr;
    in_pc = pc;
    in_hart = hart;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    flush = '0;
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_op", 32'(out_opcode), 32'(RV32_UNKNOWN));
    chk("rst_type", 32'(out_inst_type), 32'(RV32_TYPE_UNKNOWN));
    chk("rst_trap", 32'(out_trap), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h0050_0093, 32'h100, 3'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_op", 32'(out_opcode), 32'(RV32_ADDI));
    chk("addi_type", 32'(out_inst_type), 32'(RV32_TYPE_I));
    chk("addi_rd", 32'(out_rd), 32'd1);
    chk("addi_rs1", 32'(out_rs1), 32'd0);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_alu", 32'(out_alu_op), 32'(ALU_ADD));
    chk("addi_hart", 32'(out_hart), 32'd2);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_trap", 32'(out_trap), 32'd0);
    tick();
    chk("addi_popped", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h0000_0013, 32'h104, 3'd0);
    tick();
    chk("nop_op", 32'(out_opcode), 32'(RV32_NOP));
    chk("nop_type", 32'(out_inst_type), 32'(RV32_TYPE_NOP));
    chk("nop_trap", 32'(out_trap), 32'd0);
    chk("nop_imm", out_imm, 32'd0);
    drive(1'b1, 32'hFFFF_FFFF, 32'h108, 3'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    chk("ffff_op", 32'(out_opcode), 32'(RV32_UNKNOWN));
    chk("ffff_type", 32'(out_inst_type), 32'(RV32_TYPE_UNKNOWN));
    chk("ffff_trap", 32'(out_trap), 32'd1);
    chk("ffff_pc", out_pc, 32'h108);
    tick();
    chk("ffff_popped", 32'(out_valid), 32'd0);
    vq.push_back(vec_t'{32'hFE20_8CE3, RV32_BEQ, RV32_TYPE_B, 32'hFFFF_FFF8, 5'd2, 5'd0, 8'h00, 12'h000, 5'd0, 1'b0});
    vq.push_back(vec_t'{32'h1234_52B7, RV32_LUI, RV32_TYPE_U, 32'h1234_5000, 5'd0, 5'd0, 8'h00, 12'h000, 5'd0, 1'b0});
    vq.push_back(vec_t'{32'hFFDF_F06F, RV32_JAL, RV32_TYPE_J, 32'hFFFF_FFFC, 5'd0, 5'd0, 8'h00, 12'h000, 5'd0, 1'b0});
    vq.push_back(vec_t'{32'hFE20_AE23, RV32_SW, RV32_TYPE_S, 32'hFFFF_FFFC, 5'd2, 5'd0, 8'h00, 12'h000, 5'd0, 1'b0});
    vq.push_back(vec_t'{32'h4020_81B3, RV32_SUB, RV32_TYPE_R, 32'h0, 5'd2, 5'd0, 8'h00, 12'h000, 5'd0, 1'b0});
    vq.push_back(vec_t'{32'h4030_D093, RV32_SRAI, RV32_TYPE_I, 32'h403, 5'd0, 5'd3, 8'h00, 12'h000, 5'd0, 1'b0});
    vq.push_back(vec_t'{32'h0220_81B3, RV32_UNKNOWN, RV32_TYPE_UNKNOWN, 32'h0, 5'd0, 5'd0, 8'h00, 12'h000, 5'd0, 1'b1});
    vq.push_back(vec_t'{32'h0FF0_000F, RV32_FENCE, RV32_TYPE_I, 32'h0FF, 5'd0, 5'd0, 8'hFF, 12'h000, 5'd0, 1'b0});
    vq.push_back(vec_t'{32'h0000_0073, RV32_ECALL, RV32_TYPE_I, 32'h0, 5'd0, 5'd0, 8'h00, 12'h000, 5'd0, 1'b0});
    vq.push_back(vec_t'{32'h0010_0073, RV32_EBREAK, RV32_TYPE_I, 32'h1, 5'd0, 5'd0, 8'h00, 12'h000, 5'd0, 1'b0});
`ifdef RV32_DECODE_ZICSR_EN
    vq.push_back(vec_t'{32'h3000_1073, RV32_CSRRW, RV32_TYPE_I, 32'h300, 5'd0, 5'd0, 8'h00, 12'h300, 5'd0, 1'b0});
    vq.push_back(vec_t'{32'h3002_D073, RV32_CSRRWI, RV32_TYPE_I, 32'h300, 5'd0, 5'd0, 8'h00, 12'h300, 5'd5, 1'b0});
`else
    vq.push_back(vec_t'{32'h3000_1073, RV32_UNKNOWN, RV32_TYPE_UNKNOWN, 32'h0, 5'd0, 5'd0, 8'h00, 12'h000, 5'd0, 1'b1});
    vq.push_back(vec_t'{32'h3002_D073, RV32_UNKNOWN, RV32_TYPE_UNKNOWN, 32'h0, 5'd0, 5'd0, 8'h00, 12'h000, 5'd0, 1'b1});
`endif
    foreach (vq[i]) begin
      drive(1'b1, vq[i].instr, 32'h1000 + 32'(i) * 4, 3'(i));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_op", i), 32'(out_opcode), 32'(vq[i].op));
      chk($sformatf("v%0d_type", i), 32'(out_inst_type), 32'(vq[i].ty));
      chk($sformatf("v%0d_imm", i), out_imm, vq[i].imm);
      chk($sformatf("v%0d_rs2", i), 32'(out_rs2), 32'(vq[i].rs2));
      chk($sformatf("v%0d_shamt", i), 32'(out_shamt), 32'(vq[i].shamt));
      chk($sformatf("v%0d_fence", i), 32'({out_fence_pred, out_fence_succ}), 32'(vq[i].fence));
      chk($sformatf("v%0d_csr", i), 32'(out_csr), 32'(vq[i].csr));
      chk($sformatf("v%0d_zimm", i), 32'(out_zimm), 32'(vq[i].zimm));
      chk($sformatf("v%0d_trap", i), 32'(out_trap), 32'(vq[i].trap));
      chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
    end
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    tick();
    chk("stream_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h200, 3'd0);
    tick();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    chk("bp_pc1", out_pc, 32'h200);
    drive(1'b1, 32'h0000_0013, 32'h204, 3'd0);
    tick();
    chk("bp_ready2", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hFE20_8CE3, 32'h208, 3'd0);
    tick();
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_pc", out_pc, 32'h200);
    chk("bp_stall_op", 32'(out_opcode), 32'(RV32_ADDI));
    out_ready = 1'b1;
    tick();
    chk("bp_second_pc", out_pc, 32'h204);
    chk("bp_second_op", 32'(out_opcode), 32'(RV32_NOP));
    chk("bp_reopen", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    chk("bp_third_pc", out_pc, 32'h208);
    chk("bp_third_op", 32'(out_opcode), 32'(RV32_BEQ));
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h300, 3'd1);
    tick();
    drive(1'b1, 32'h0000_0013, 32'h304, 3'd3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    chk("fl_full", 32'(in_ready), 32'd0);
    flush = 8'b0000_0010;
    tick();
    flush = '0;
    chk("fl_valid", 32'(out_valid), 32'd1);
    chk("fl_hart", 32'(out_hart), 32'd3);
    chk("fl_pc", out_pc, 32'h304);
    chk("fl_one", 32'(in_ready), 32'd1);
    flush = 8'b0000_1000;
    tick();
    chk("fl_last", 32'(out_valid), 32'd0);
    flush = 8'b0001_0000;
    drive(1'b1, 32'h0050_0093, 32'h310, 3'd4);
    tick();
    flush = '0;
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    chk("fl_in_dropped", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h0050_0093, 32'h400, 3'd5);
    tick();
    drive(1'b1, 32'h0000_0013, 32'h404, 3'd6);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    out_ready = 1'b1;
    flush = 8'b0010_0000;
    tick();
    flush = '0;
    chk("flpop_valid", 32'(out_valid), 32'd1);
    chk("flpop_hart", 32'(out_hart), 32'd6);
    chk("flpop_pc", out_pc, 32'h404);
    tick();
    chk("flpop_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h500, 3'd1);
    tick();
    drive(1'b1, 32'hFFFF_FFFF, 32'h504, 3'd2);
    tick();
    chk("rst2_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    out_ready = 1'b1;
    flush = 8'hFF;
    drive(1'b1, 32'h0000_0013, 32'h508, 3'd3);
    tick();
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_ready", 32'(in_ready), 32'd1);
    chk("rst2_op", 32'(out_opcode), 32'(RV32_UNKNOWN));
    chk("rst2_trap", 32'(out_trap), 32'd0);
    chk("rst2_pc", out_pc, 32'd0);
    chk("rst2_imm", out_imm, 32'd0);
    chk("rst2_hart", 32'(out_hart), 32'd0);
    rst_n = 1'b1;
    flush = '0;
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    tick();
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv32_decode_stage.md
RV32_DECODE_STAGE -- requirements
Module: rv32_decode_stage

Interface
REQ-001 Parameter NUM_HARTS, default 8, number of hardware threads sharing the stage; SHALL be 1..32.
REQ-002 Parameter HART_W, default $clog2(NUM_HARTS) (minimum 1), width of hart-ID fields.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid / in_ready  input / output  1 / 1  fetch-side handshake.
REQ-006 in_instr / in_pc / in_hart  input  32 / 32 / HART_W  fetched word, its PC, and its hart.
REQ-007 flush  input  NUM_HARTS  per-hart kill mask.
REQ-008 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-009 out_opcode, out_inst_type, out_alu_op  output  rv32_opcode_enum_t, rv32_type_enum_t, rv32_alu_op_t  decoded instruction class.
REQ-010 out_rs1 / out_rs2 / out_rd / out_shamt  output  5 each  register and shift fields.
REQ-011 out_imm / out_csr / out_zimm  output  32 / 12 / 5  immediate, CSR address, CSR zero-extended immediate.
REQ-012 out_fence_pred / out_fence_succ  output  4 / 4  FENCE ordering fields.
REQ-013 out_trap / out_pc / out_hart  output  1 / 32 / HART_W  illegal-instruction flag and pass-through tags.

Function
REQ-014 Transfers SHALL occur only when valid and ready are both high on a rising edge.
REQ-015 Decode SHALL be combinational on in_instr; the result plus in_pc and in_hart SHALL be registered into a 2-entry FIFO (skid buffer). All out_* SHALL come from the head entry only.
REQ-016 Latency SHALL be 1 cycle: an instruction accepted at edge N appears on out_* with out_valid=1 after edge N, if the FIFO was empty.
REQ-017 Throughput SHALL be one instruction per cycle while out_ready=1.
REQ-018 FIFO states: EMPTY, ONE, FULL. Push only: EMPTY->ONE, ONE->FULL. Pop only: FULL->ONE, ONE->EMPTY. Simultaneous push and pop SHALL leave the state unchanged and preserve order.
REQ-019 in_ready SHALL be a register, 1 in EMPTY and ONE and 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL be 1 exactly in ONE and FULL. out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Flush: in the cycle flush[h]=1, every stored entry with hart h SHALL be removed; an entry behind a removed head SHALL advance to the head. An input beat with in_hart=h SHALL be consumed (in_ready unaffected) but not stored.
REQ-022 A flush that coincides with a pop of the same entry SHALL count that entry once. Surviving entries SHALL keep their order.
REQ-023 Decode SHALL cover all RV32I opcodes, FENCE, FENCE.I, ECALL and EBREAK. Words 0x00000013 SHALL decode as RV32_NOP with type RV32_TYPE_NOP.
REQ-024 An unknown encoding, including a known opcode with an illegal funct3 or funct7, SHALL give out_opcode=RV32_UNKNOWN, type RV32_TYPE_UNKNOWN and out_trap=1.
REQ-025 Immediates SHALL be sign-extended to 32 bits per type I/S/B/U/J, with bit 0 forced to 0 for B and J. out_imm SHALL be 0 for R, NOP and UNKNOWN.
REQ-026 Fields not meaningful for the decoded type (fence, csr, zimm) SHALL be driven 0, never latched.

Reset
REQ-027 When rst_n=0 at an edge, the FIFO SHALL go EMPTY, out_valid=0, in_ready=1, and all out_* payload SHALL be 0 (out_opcode=RV32_UNKNOWN, out_inst_type=RV32_TYPE_UNKNOWN, out_trap=0).
REQ-028 Reset SHALL override push, pop and flush in the same cycle; in-flight entries SHALL be discarded.

Configuration
REQ-029 With macro RV32_DECODE_ZICSR_EN defined:
- CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI and CSRRCI SHALL decode.
- out_csr SHALL be instr[31:20].
- out_zimm SHALL be instr[19:15] for the immediate forms.
REQ-030 Without RV32_DECODE_ZICSR_EN:
- Those encodings SHALL decode as RV32_UNKNOWN with out_trap=1.
- out_csr and out_zimm SHALL be tied to 0.

Structure
REQ-031 rv32_opcode_enum_t, rv32_type_enum_t, rv32_alu_op_t, the ALU op constants and the decode-entry struct SHALL live in the shared rv32 package.
REQ-032 Combinational decode SHALL be a sub-module, rv32_decode_core, with one instance. The FIFO and flush logic SHALL stay in rv32_decode_stage.

Verification
REQ-033 Push 0x00500093 (ADDI x1,x0,5), hart 2, PC 0x100, out_ready=1 -> next cycle: RV32_ADDI, rd=1, rs1=0, imm=5, out_hart=2, out_pc=0x100, out_trap=0.
REQ-034 Push 0x00000013, then 0xFFFFFFFF -> first: RV32_NOP, type NOP, trap=0. Second: RV32_UNKNOWN, trap=1.
REQ-035 Hold out_ready=0 and push 3 back-to-back words -> in_ready=0 after the second accept. Release out_ready -> both words are delivered in order, the third is accepted, and nothing is lost.
REQ-036 FIFO FULL with hart 1 at head and hart 3 behind; pulse flush=8'b00000010 -> the hart-3 entry appears at the head in the next cycle and the state is ONE.
REQ-037 Push 0x30001073 (CSRRW mstatus) -> with the macro: RV32_CSRRW, csr=0x300, trap=0. Without the macro: RV32_UNKNOWN, trap=1.
REQ-038 rst_n=0 for one cycle while FULL, with push and flush active -> after that edge: out_valid=0, in_ready=1, payload 0.
